// File: rtl/audio_minmax_pkg.sv
// Shared defaults and types for the audio interval min/max pass.
package audio_minmax_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_LEN_W  = 16;

   // Sample RAM read latency in cycles (data valid this many cycles after the strobe)
   localparam int RD_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

endpackage

// File: rtl/interval_minmax_core.sv
// Streaming signed min/max accumulator: one sample per valid cycle, result
// registered the cycle after the interval's last sample.
module interval_minmax_core
   import audio_minmax_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic              in_last,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_min,
   output logic [DATA_W-1:0] out_max
);

   logic [DATA_W-1:0] min_q, max_q, min_d, max_d;
   logic [DATA_W-1:0] out_min_q, out_max_q;
   logic              out_valid_q;

   // Next running extremes: first sample seeds both, later samples update min and max independently
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (in_first) begin
         min_d = in_data;
         max_d = in_data;
      end else begin
         if ($signed(in_data) < $signed(min_q)) begin
            min_d = in_data;
         end else begin
            min_d = min_q;
         end
         if ($signed(in_data) > $signed(max_q)) begin
            max_d = in_data;
         end else begin
            max_d = max_q;
         end
      end
   end

   // Accumulator state and registered per-interval result
   always_ff @(posedge clk) begin
      if (reset) begin
         min_q       <= '0;
         max_q       <= '0;
         out_min_q   <= '0;
         out_max_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid && in_last;
         if (in_valid) begin
            min_q <= min_d;
            max_q <= max_d;
         end else begin
            min_q <= min_q;
            max_q <= max_q;
         end
         if (in_valid && in_last) begin
            out_min_q <= min_d;
            out_max_q <= max_d;
         end else begin
            out_min_q <= out_min_q;
            out_max_q <= out_max_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_min   = out_min_q;
   assign out_max   = out_max_q;

endmodule

// File: rtl/audio_interval_scheduler.sv
// Sequences one min/max pass: reads S samples, splits them into L-sized
// intervals (trailing partial kept) and writes one (min,max) per interval.
module audio_interval_scheduler
   import audio_minmax_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   cfg_num_samples,
   input  logic [LEN_W-1:0]  cfg_interval_len,
   output logic              busy,
   output logic              done,
   output logic              err_cfg,
   output logic              smp_rd_en,
   output logic [ADDR_W-1:0] smp_rd_addr,
   input  logic [DATA_W-1:0] smp_rd_data,
   output logic              res_wr_en,
   output logic [ADDR_W-1:0] res_wr_addr,
   output logic [DATA_W-1:0] res_wr_min,
   output logic [DATA_W-1:0] res_wr_max,
   output logic [ADDR_W:0]   res_count
);

   localparam logic [ADDR_W:0] MAX_S = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q;
   logic              busy_q, done_q, err_q, rd_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  pos_q;
   logic [ADDR_W:0]   s_q;
   logic [LEN_W-1:0]  l_q;
   logic [ADDR_W:0]   wr_idx_q;
   logic [ADDR_W:0]   res_count_q;
   logic [RD_LAT-1:0] vld_pipe_q, first_pipe_q, last_pipe_q;

   logic cfg_bad_d, addr_last_d, first_d, last_d;
   logic core_valid;

   // Per-read interval markers and configuration check, all from latched S/L
   always_comb begin
      cfg_bad_d   = (l_q == LEN_W'(0)) || (s_q == (ADDR_W+1)'(0)) || (s_q > MAX_S);
      addr_last_d = ({1'b0, addr_q} == (s_q - (ADDR_W+1)'(1)));
      first_d     = (pos_q == LEN_W'(0));
      last_d      = (pos_q == (l_q - LEN_W'(1))) || addr_last_d;
   end

   // Delay the read strobe and its markers so they line up with returned data
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q   <= '0;
         first_pipe_q <= '0;
         last_pipe_q  <= '0;
      end else begin
         vld_pipe_q   <= (vld_pipe_q   << 1) | RD_LAT'(rd_en_q);
         first_pipe_q <= (first_pipe_q << 1) | RD_LAT'(first_d);
         last_pipe_q  <= (last_pipe_q  << 1) | RD_LAT'(last_d);
      end
   end

   interval_minmax_core #(.DATA_W(DATA_W)) u_core (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vld_pipe_q[RD_LAT-1]),
      .in_first  (first_pipe_q[RD_LAT-1]),
      .in_last   (last_pipe_q[RD_LAT-1]),
      .in_data   (smp_rd_data),
      .out_valid (core_valid),
      .out_min   (res_wr_min),
      .out_max   (res_wr_max)
   );

   // Pass control FSM: addressing, interval position, write index and handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         pos_q       <= '0;
         s_q         <= '0;
         l_q         <= '0;
         wr_idx_q    <= '0;
         res_count_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (core_valid) begin
            wr_idx_q <= wr_idx_q + (ADDR_W+1)'(1);
         end else begin
            wr_idx_q <= wr_idx_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  s_q         <= cfg_num_samples;
                  l_q         <= cfg_interval_len;
                  busy_q      <= 1'b1;
                  res_count_q <= '0;
                  state_q     <= ST_CHECK;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               if (cfg_bad_d) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  rd_en_q  <= 1'b1;
                  addr_q   <= '0;
                  pos_q    <= '0;
                  wr_idx_q <= '0;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // One read per cycle; interval position wraps on each closing sample
               pos_q <= last_d ? LEN_W'(0) : (pos_q + LEN_W'(1));
               if (addr_last_d) begin
                  rd_en_q <= 1'b0;
                  state_q <= ST_DRAIN;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               // Final write is the one with no sample left in flight behind it
               if (core_valid && !vld_pipe_q[RD_LAT-1]) begin
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  res_count_q <= wr_idx_q + (ADDR_W+1)'(1);
                  state_q     <= ST_FINISH;
               end else begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_cfg     = err_q;
   assign smp_rd_en   = rd_en_q;
   assign smp_rd_addr = addr_q;
   assign res_wr_en   = core_valid;
   assign res_wr_addr = wr_idx_q[ADDR_W-1:0];
   assign res_count   = res_count_q;

endmodule

// File: tb/tb_audio_interval_scheduler.sv
// Directed bench for audio_interval_scheduler: cycle-accurate pass monitor
// with hand-computed expectations.
module tb_audio_interval_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] cfg_num_samples;
   logic [15:0] cfg_interval_len;
   logic        busy, done, err_cfg, smp_rd_en, res_wr_en;
   logic [9:0]  smp_rd_addr, res_wr_addr;
   logic [31:0] smp_rd_data = 32'd0;
   logic [31:0] res_wr_min, res_wr_max;
   logic [10:0] res_count;

   logic [31:0] ram [0:1023];

   int n_cmp = 0;
   int n_bad = 0;

   // pass monitor results
   int          cyc, n_reads, rd_order_bad, first_rd, last_rd;
   int          n_wr, first_wr, last_wr, done_cyc, n_err, post_rst_evt;
   bit          finished, err_at_done, busy_c1, busy_at_done, busy_after_rst, rden_after_rst;
   logic [10:0] count_at_done;
   logic [9:0]  wr_k   [0:63];
   logic [31:0] wr_min [0:63];
   logic [31:0] wr_max [0:63];

   always #5 clk = ~clk;

   // sample RAM model, one-cycle read latency
   always @(posedge clk) begin
      if (smp_rd_en) smp_rd_data <= ram[smp_rd_addr];
   end

   audio_interval_scheduler dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .cfg_num_samples  (cfg_num_samples),
      .cfg_interval_len (cfg_interval_len),
      .busy             (busy),
      .done             (done),
      .err_cfg          (err_cfg),
      .smp_rd_en        (smp_rd_en),
      .smp_rd_addr      (smp_rd_addr),
      .smp_rd_data      (smp_rd_data),
      .res_wr_en        (res_wr_en),
      .res_wr_addr      (res_wr_addr),
      .res_wr_min       (res_wr_min),
      .res_wr_max       (res_wr_max),
      .res_count        (res_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 1024; i++) ram[i] = 32'(i);
   endtask

   // Start a pass (cycle 0 = start sampled), monitor every cycle at negedge.
   task automatic run_pass(input int s, input int l, input int poke_cyc, input int rst_cyc, input int max_cyc);
      repeat (2) @(negedge clk);
      n_reads = 0; rd_order_bad = 0; first_rd = -1; last_rd = -1;
      n_wr = 0; first_wr = -1; last_wr = -1; done_cyc = -1; n_err = 0; post_rst_evt = 0;
      finished = 1'b0; err_at_done = 1'b0; busy_c1 = 1'b0; busy_at_done = 1'b1;
      busy_after_rst = 1'b1; rden_after_rst = 1'b1; count_at_done = 11'h7ff;
      cfg_num_samples  = 11'(s);
      cfg_interval_len = 16'(l);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!finished && cyc <= max_cyc) begin
         if (cyc == 1) busy_c1 = busy;
         if (cyc == poke_cyc) begin
            start = 1'b1; cfg_num_samples = 11'd3; cfg_interval_len = 16'd0;
         end else begin
            start = 1'b0;
         end
         if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
            busy_after_rst = busy;
            rden_after_rst = smp_rd_en;
            reset = 1'b0;
         end
         if (rst_cyc > 0 && cyc > rst_cyc && (smp_rd_en || res_wr_en || done)) post_rst_evt++;
         if (smp_rd_en) begin
            if (smp_rd_addr != 10'(n_reads)) rd_order_bad++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            n_reads++;
         end
         if (res_wr_en) begin
            if (n_wr < 64) begin
               wr_k[n_wr] = res_wr_addr; wr_min[n_wr] = res_wr_min; wr_max[n_wr] = res_wr_max;
            end
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
         end
         if (err_cfg) n_err++;
         if (done) begin
            done_cyc = cyc; err_at_done = err_cfg; busy_at_done = busy;
            count_at_done = res_count; finished = 1'b1;
         end
         if (rst_cyc > 0 && cyc == rst_cyc) reset = 1'b1;
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_pass(input string p, input int s, input int l);
      int nk = (s + l - 1) / l;
      check({p, " done_seen"}, finished, 1);
      check({p, " reads"}, n_reads, s);
      check({p, " read_order"}, rd_order_bad, 0);
      check({p, " first_read_cyc"}, first_rd, 2);
      check({p, " last_read_cyc"}, last_rd, s + 1);
      check({p, " writes"}, n_wr, nk);
      check({p, " last_write_cyc"}, last_wr, s + 3);
      check({p, " done_cyc"}, done_cyc, s + 4);
      check({p, " err_pulses"}, n_err, 0);
      check({p, " busy_cyc1"}, busy_c1, 1);
      check({p, " busy_at_done"}, busy_at_done, 0);
      check({p, " res_count"}, count_at_done, nk);
   endtask

   task automatic check_ramp(input string p, input int s, input int l);
      int nk = (s + l - 1) / l;
      for (int k = 0; k < nk && k < 64; k++) begin
         int hi = k * l + l - 1;
         if (hi > s - 1) hi = s - 1;
         check($sformatf("%s k%0d addr", p, k), wr_k[k], k);
         check($sformatf("%s k%0d min", p, k), wr_min[k], k * l);
         check($sformatf("%s k%0d max", p, k), wr_max[k], hi);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      cfg_num_samples = 11'd0; cfg_interval_len = 16'd0;
      load_ramp();
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err_cfg", err_cfg, 0);
      check("rst rd_en", smp_rd_en, 0);
      check("rst rd_addr", smp_rd_addr, 0);
      check("rst wr_en", res_wr_en, 0);
      check("rst wr_addr", res_wr_addr, 0);
      check("rst wr_min", res_wr_min, 0);
      check("rst wr_max", res_wr_max, 0);
      check("rst res_count", res_count, 0);
      reset = 1'b0;

      // S=20, L=10 ramp, with a stray start (bad config) while busy
      run_pass(20, 10, 5, -1, 60);
      check_pass("s20l10", 20, 10);
      check_ramp("s20l10", 20, 10);

      // S=25, L=10: trailing partial interval
      run_pass(25, 10, -1, -1, 60);
      check_pass("s25l10", 25, 10);
      check_ramp("s25l10", 25, 10);

      // S=8, L=4: signed extremes
      ram[0] = 32'd5; ram[1] = 32'd4; ram[2] = 32'd3; ram[3] = 32'd2;
      ram[4] = 32'hFFFF_FFFF; ram[5] = 32'd7; ram[6] = 32'h8000_0000; ram[7] = 32'h7FFF_FFFF;
      run_pass(8, 4, -1, -1, 40);
      check_pass("s8l4", 8, 4);
      check("s8l4 k0 min", wr_min[0], 32'd2);
      check("s8l4 k0 max", wr_max[0], 32'd5);
      check("s8l4 k1 addr", wr_k[1], 10'd1);
      check("s8l4 k1 min", wr_min[1], 32'h8000_0000);
      check("s8l4 k1 max", wr_max[1], 32'h7FFF_FFFF);
      load_ramp();

      // S=8, L=1: a write every cycle
      run_pass(8, 1, -1, -1, 40);
      check_pass("s8l1", 8, 1);
      check("s8l1 first_write_cyc", first_wr, 4);
      check_ramp("s8l1", 8, 1);

      // L > S: one partial interval
      run_pass(8, 100, -1, -1, 40);
      check_pass("s8l100", 8, 100);
      check_ramp("s8l100", 8, 100);

      // L=0: error, with start pulsed during CHECK
      run_pass(8, 0, 1, -1, 40);
      check("l0 done_seen", finished, 1);
      check("l0 done_cyc", done_cyc, 2);
      check("l0 err_with_done", err_at_done, 1);
      check("l0 err_pulses", n_err, 1);
      check("l0 reads", n_reads, 0);
      check("l0 writes", n_wr, 0);
      check("l0 res_count", count_at_done, 0);

      // S > 2**ADDR_W: error
      run_pass(1025, 4, -1, -1, 40);
      check("s1025 done_cyc", done_cyc, 2);
      check("s1025 err_with_done", err_at_done, 1);
      check("s1025 reads", n_reads, 0);
      check("s1025 res_count", count_at_done, 0);

      // reset at cycle 6 of S=20 pass
      run_pass(20, 10, -1, 6, 40);
      check("rstmid no_done", finished, 0);
      check("rstmid busy_after", busy_after_rst, 0);
      check("rstmid rden_after", rden_after_rst, 0);
      check("rstmid late_strobes", post_rst_evt, 0);
      check("rstmid res_count", res_count, 0);

      // fresh pass after the abort
      run_pass(20, 10, -1, -1, 60);
      check_pass("fresh", 20, 10);
      check_ramp("fresh", 20, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
